// File: rtl/ic7421_bist_pkg.sv
// rtl/ic7421_bist_pkg.sv - shared types, constants and golden function for the ic7421 BIST
package ic7421_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int NUM_VECTORS = 256;

  localparam int STIM_A1  = 0;
  localparam int STIM_B2  = 1;
  localparam int STIM_C4  = 2;
  localparam int STIM_D5  = 3;
  localparam int STIM_A9  = 4;
  localparam int STIM_B10 = 5;
  localparam int STIM_C12 = 6;
  localparam int STIM_D13 = 7;

  // Returns {exp8, exp6}: each gate output is the AND of its four inputs.
  function automatic logic [1:0] expected_outputs(input logic [7:0] vec);
    logic exp6;
    logic exp8;
    exp6 = vec[STIM_A1] & vec[STIM_B2] & vec[STIM_C4] & vec[STIM_D5];
    exp8 = vec[STIM_A9] & vec[STIM_B10] & vec[STIM_C12] & vec[STIM_D13];
    return {exp8, exp6};
  endfunction

endpackage

// File: rtl/ic7421_bist_ctrl_if.sv
// rtl/ic7421_bist_ctrl_if.sv - control, gate-return and result signals of the ic7421 BIST
interface ic7421_bist_ctrl_if #(
  parameter int ERR_W = 9
);
  logic             start_in;
  logic             abort_in;
  logic             y_out_6_in;
  logic             y_out_8_in;
  logic [7:0]       stim_out;
  logic             busy_out;
  logic             done_out;
  logic             pass_out;
  logic             aborted_out;
  logic [ERR_W-1:0] err_count_out;
  logic [7:0]       first_fail_vec_out;
  logic             first_fail_valid_out;

  modport master (
    input  start_in, abort_in, y_out_6_in, y_out_8_in,
    output stim_out, busy_out, done_out, pass_out, aborted_out,
    output err_count_out, first_fail_vec_out, first_fail_valid_out
  );

  modport slave (
    output start_in, abort_in, y_out_6_in, y_out_8_in,
    input  stim_out, busy_out, done_out, pass_out, aborted_out,
    input  err_count_out, first_fail_vec_out, first_fail_valid_out
  );
endinterface

// File: rtl/ic7421_ref_model.sv
// rtl/ic7421_ref_model.sv - combinational golden model of the dual 4-input AND gate
module ic7421_ref_model
  import ic7421_bist_pkg::*;
(
  input  logic [7:0] vec_in,
  output logic       exp6_out,
  output logic       exp8_out
);
  assign {exp8_out, exp6_out} = expected_outputs(vec_in);
endmodule

// File: rtl/ic7421_bist_ctrl.sv
// rtl/ic7421_bist_ctrl.sv - exhaustive 256-vector sweep and checker for an ic7421 instance
module ic7421_bist_ctrl
  import ic7421_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 9
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  ic7421_bist_ctrl_if.master  bist
);

  localparam logic [3:0]       SETTLE_M1 = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [8:0]       LAST_VEC  = 9'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic [8:0]       vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       ff_vec_q, ff_vec_d;
  logic             ff_valid_q, ff_valid_d;
  logic             aborted_q, aborted_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       stim_q, stim_d;
  logic             y6_q, y6_d;
  logic             y8_q, y8_d;
  logic             exp6, exp8;
  logic             mismatch;
  logic             running;

  ic7421_ref_model u_ref (
    .vec_in   (vec_q[7:0]),
    .exp6_out (exp6),
    .exp8_out (exp8)
  );

  // Gate outputs are registered every edge; in CHECK they hold the value seen on the
  // last edge of the settle window, while stim_out is still the vector under test.
  assign y6_d     = bist.y_out_6_in;
  assign y8_d     = bist.y_out_8_in;
  assign mismatch = (y6_q != exp6) || (y8_q != exp8);
  assign running  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    err_d      = err_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    aborted_d  = aborted_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = done_q;
    stim_d     = stim_q;

    if (running && bist.abort_in) begin
      state_d   = ST_DONE;
      aborted_d = 1'b1;
      pass_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      stim_d    = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bist.start_in) begin
            state_d    = ST_APPLY;
            vec_d      = 9'd0;
            settle_d   = 4'd0;
            err_d      = '0;
            ff_vec_d   = 8'h00;
            ff_valid_d = 1'b0;
            aborted_d  = 1'b0;
            pass_d     = 1'b0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            stim_d     = 8'h00;
          end
        end
        ST_APPLY: begin
          if (SETTLE_CYCLES == 0) begin
            state_d = ST_CHECK;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_M1;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 4'd0) begin
            state_d = ST_CHECK;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            if (!ff_valid_q) begin
              ff_vec_d   = vec_q[7:0];
              ff_valid_d = 1'b1;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = 8'h00;
          end else begin
            state_d = ST_APPLY;
            vec_d   = vec_q + 9'd1;
            stim_d  = vec_d[7:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      vec_q      <= 9'd0;
      settle_q   <= 4'd0;
      err_q      <= '0;
      ff_vec_q   <= 8'h00;
      ff_valid_q <= 1'b0;
      aborted_q  <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stim_q     <= 8'h00;
      y6_q       <= 1'b0;
      y8_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
      aborted_q  <= aborted_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stim_q     <= stim_d;
      y6_q       <= y6_d;
      y8_q       <= y8_d;
    end
  end

  assign bist.stim_out             = stim_q;
  assign bist.busy_out             = busy_q;
  assign bist.done_out             = done_q;
  assign bist.pass_out             = pass_q;
  assign bist.aborted_out          = aborted_q;
  assign bist.err_count_out        = err_q;
  assign bist.first_fail_vec_out   = ff_vec_q;
  assign bist.first_fail_valid_out = ff_valid_q;

endmodule

// File: tb/tb_ic7421_bist_ctrl.sv
// tb/tb_ic7421_bist_ctrl.sv - scoreboard bench for the ic7421 BIST sequencer
module tb_ic7421_bist_ctrl;

  typedef struct {
    int done_cyc;
    int err;
    bit pass;
    bit aborted;
    bit ffv;
    int ff_vec;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ic7421_bist_ctrl_if #(.ERR_W(9)) a_if ();
  ic7421_bist_ctrl_if #(.ERR_W(4)) b_if ();

  ic7421_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(9)) dut_a (
    .clk_in   (clk),
    .rst_n_in (rst_a),
    .bist     (a_if.master)
  );

  ic7421_bist_ctrl #(.SETTLE_CYCLES(0), .ERR_W(4)) dut_b (
    .clk_in   (clk),
    .rst_n_in (rst_b),
    .bist     (b_if.master)
  );

  int checks = 0;
  int errors = 0;
  int a_mode = 0;
  int b_mode = 0;
  bit [255:0] bad6;
  bit [255:0] bad8;
  int a_n = 0;
  int a_end = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  bit a_done_prev = 1'b0;
  bit b_done_prev = 1'b0;
  exp_t a_q[$];
  exp_t b_q[$];

  // Fault injection around an ideal gate: 1 = y6 stuck 0, 2 = y8 stuck 1, 3 = random flips.
  assign a_if.y_out_6_in = (a_mode == 1) ? 1'b0 :
                           ((a_if.stim_out[3:0] == 4'hF) ^ (a_mode == 3 && bad6[a_if.stim_out]));
  assign a_if.y_out_8_in = (a_mode == 2) ? 1'b1 :
                           ((a_if.stim_out[7:4] == 4'hF) ^ (a_mode == 3 && bad8[a_if.stim_out]));
  assign b_if.y_out_6_in = (b_if.stim_out[3:0] == 4'hF);
  assign b_if.y_out_8_in = (b_mode == 2) ? 1'b1 : (b_if.stim_out[7:4] == 4'hF);

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int mode, input int nvec, input int errw,
                                 input int done_cyc, input bit aborted);
    exp_t e;
    int cnt;
    bit g6, g8, o6, o8;
    cnt = 0;
    e.ffv = 1'b0;
    e.ff_vec = 0;
    for (int v = 0; v < nvec; v++) begin
      g6 = (v % 16 == 15);
      g8 = (v / 16 == 15);
      o6 = g6;
      o8 = g8;
      case (mode)
        1: o6 = 1'b0;
        2: o8 = 1'b1;
        3: begin o6 = g6 ^ bad6[v]; o8 = g8 ^ bad8[v]; end
        default: ;
      endcase
      if (o6 != g6 || o8 != g8) begin
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ff_vec = v;
        end
        cnt++;
      end
    end
    e.err = (cnt > (1 << errw) - 1) ? (1 << errw) - 1 : cnt;
    e.aborted = aborted;
    e.pass = (cnt == 0) && !aborted;
    e.done_cyc = done_cyc;
    return e;
  endfunction

  task automatic check_exp(input string tag, input exp_t e, input int err, input bit pass,
                           input bit ab, input bit ffv, input int ffvec, input int stim,
                           input bit busy);
    cmp({tag, "_done_cycle"}, cyc, e.done_cyc);
    cmp({tag, "_err_count"}, err, e.err);
    cmp({tag, "_pass"}, int'(pass), int'(e.pass));
    cmp({tag, "_aborted"}, int'(ab), int'(e.aborted));
    cmp({tag, "_ff_valid"}, int'(ffv), int'(e.ffv));
    if (e.ffv) cmp({tag, "_ff_vec"}, ffvec, e.ff_vec);
    cmp({tag, "_stim_idle"}, stim, 0);
    cmp({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_a && a_if.done_out && !a_done_prev) begin
      a_done_cnt++;
      if (a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done: done rose at cycle %0d with no expected run", cyc);
      end else begin
        e = a_q.pop_front();
        check_exp("a", e, int'(a_if.err_count_out), a_if.pass_out, a_if.aborted_out,
                  a_if.first_fail_valid_out, int'(a_if.first_fail_vec_out),
                  int'(a_if.stim_out), a_if.busy_out);
      end
    end
    a_done_prev = a_if.done_out;
    if (rst_a && cyc >= a_n && cyc < a_end) begin
      cmp("a_busy_run", int'(a_if.busy_out), 1);
      cmp("a_stim_seq", int'(a_if.stim_out), (cyc - a_n) / 4);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_b && b_if.done_out && !b_done_prev) begin
      b_done_cnt++;
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_done: done rose at cycle %0d with no expected run", cyc);
      end else begin
        e = b_q.pop_front();
        check_exp("b", e, int'(b_if.err_count_out), b_if.pass_out, b_if.aborted_out,
                  b_if.first_fail_valid_out, int'(b_if.first_fail_vec_out),
                  int'(b_if.stim_out), b_if.busy_out);
      end
    end
    b_done_prev = b_if.done_out;
  end

  task automatic a_start(input int mode, input bit push);
    a_mode = mode;
    @(posedge clk);
    #1;
    a_if.start_in = 1'b1;
    a_n = cyc + 1;
    a_end = a_n + 1024;
    if (push) a_q.push_back(model(mode, 256, 9, a_end, 1'b0));
    @(posedge clk);
    #1;
    a_if.start_in = 1'b0;
    cmp("a_clr_err", int'(a_if.err_count_out), 0);
    cmp("a_clr_ffv", int'(a_if.first_fail_valid_out), 0);
    cmp("a_clr_aborted", int'(a_if.aborted_out), 0);
    cmp("a_clr_done", int'(a_if.done_out), 0);
  endtask

  task automatic a_wait(input int budget, input string tag);
    int c0;
    bit got;
    c0 = a_done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (a_done_cnt != c0) begin
        got = 1'b1;
        break;
      end
    end
    cmp({tag, "_done_seen"}, int'(got), 1);
  endtask

  task automatic b_run(input int mode, input string tag);
    int c0;
    bit got;
    b_mode = mode;
    @(posedge clk);
    #1;
    b_if.start_in = 1'b1;
    b_q.push_back(model(mode, 256, 4, cyc + 1 + 512, 1'b0));
    @(posedge clk);
    #1;
    b_if.start_in = 1'b0;
    c0 = b_done_cnt;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      if (b_done_cnt != c0) begin
        got = 1'b1;
        break;
      end
    end
    cmp({tag, "_done_seen"}, int'(got), 1);
  endtask

  task automatic a_check_zero(input string tag);
    cmp({tag, "_stim"}, int'(a_if.stim_out), 0);
    cmp({tag, "_busy"}, int'(a_if.busy_out), 0);
    cmp({tag, "_done"}, int'(a_if.done_out), 0);
    cmp({tag, "_pass"}, int'(a_if.pass_out), 0);
    cmp({tag, "_aborted"}, int'(a_if.aborted_out), 0);
    cmp({tag, "_err"}, int'(a_if.err_count_out), 0);
    cmp({tag, "_ffvec"}, int'(a_if.first_fail_vec_out), 0);
    cmp({tag, "_ffvalid"}, int'(a_if.first_fail_valid_out), 0);
  endtask

  initial begin
    bit found;
    rst_a = 1'b0;
    rst_b = 1'b0;
    a_if.start_in = 1'b0;
    a_if.abort_in = 1'b0;
    b_if.start_in = 1'b0;
    b_if.abort_in = 1'b0;
    bad6 = '0;
    bad8 = '0;
    repeat (3) @(posedge clk);
    #1;
    a_check_zero("a_reset");
    cmp("b_reset_stim", int'(b_if.stim_out), 0);
    cmp("b_reset_err", int'(b_if.err_count_out), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    a_start(0, 1'b1);
    a_wait(1100, "a_fault_free");
    a_start(1, 1'b1);
    a_wait(1100, "a_y6_stuck0");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        bad6[i] = ($urandom_range(31) == 0);
        bad8[i] = ($urandom_range(31) == 0);
      end
      a_start(3, 1'b1);
      a_wait(1100, "a_random_fault");
    end

    a_start(0, 1'b1);
    repeat ($urandom_range(900, 100)) @(posedge clk);
    #1;
    a_if.start_in = 1'b1;
    @(posedge clk);
    #1;
    a_if.start_in = 1'b0;
    a_wait(1100, "a_start_ignored");

    a_start(2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_if.stim_out == 8'h40) begin
        found = 1'b1;
        break;
      end
    end
    cmp("a_reach_0x40", int'(found), 1);
    if (found) begin
      a_if.abort_in = 1'b1;
      a_end = cyc + 1;
      a_q.push_back(model(2, 64, 9, cyc + 1, 1'b1));
      @(posedge clk);
      #1;
      a_if.abort_in = 1'b0;
      a_wait(10, "a_abort");
    end
    a_start(0, 1'b1);
    a_wait(1100, "a_rerun");

    a_start(0, 1'b0);
    repeat ($urandom_range(500, 50)) @(posedge clk);
    #3;
    a_end = 0;
    rst_a = 1'b0;
    #1;
    a_check_zero("a_midrun_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    a_start(0, 1'b1);
    a_wait(1100, "a_after_reset");

    a_mode = 0;
    @(posedge clk);
    #1;
    a_if.start_in = 1'b1;
    a_n = cyc + 1;
    a_end = a_n + 1024;
    a_q.push_back(model(0, 256, 9, a_end, 1'b0));
    a_q.push_back(model(0, 256, 9, a_end + 1025, 1'b0));
    a_wait(1100, "a_held1");
    a_n = a_end + 1;
    a_end = a_n + 1024;
    a_if.start_in = 1'b0;
    cmp("a_held_done_pulse", int'(a_if.done_out), 0);
    cmp("a_held_restart_busy", int'(a_if.busy_out), 1);
    a_wait(1100, "a_held2");

    b_run(0, "b_settle0");
    b_run(2, "b_saturate");

    repeat (5) @(posedge clk);
    cmp("a_queue_drained", a_q.size(), 0);
    cmp("b_queue_drained", b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic7421_bist_ctrl.md
# ic7421_bist_ctrl

Built-in self-test sequencer for the dual 4-input AND gate IC (ic7421). On a start request it applies all 256 combinations to the eight gate inputs. After each vector it waits a programmable settle time and checks both outputs against the AND of their inputs. It counts mismatching vectors and reports pass/fail, the error count and the first failing vector. It sits beside an ic7421 instance as its stimulus source and checker, replacing free-running bench stimulus with a deterministic, self-checking sweep.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: wait cycles between applying a vector and sampling outputs; range 0–15.
- ERR_W, default 9: width of the error counter; saturates at all-ones.

Ports:
- clk_in  input  1  Single clock; all state changes on its rising edge.
- rst_n_in  input  1  Reset, asynchronous and active-low.
- start_in  input  1  Start request, sampled each edge. Accepted only in IDLE or DONE; ignored while busy.
- abort_in  input  1  Ends an active run early.
- y_out_6_in  input  1  Gate-1 output returned from the ic7421 instance.
- y_out_8_in  input  1  Gate-2 output returned from the ic7421 instance.
- stim_out  output  8  Gate input vector:
  - bit0 a_in_1, bit1 b_in_2, bit2 c_in_4, bit3 d_in_5
  - bit4 a_in_9, bit5 b_in_10, bit6 c_in_12, bit7 d_in_13
- busy_out  output  1  High while a run is active.
- done_out  output  1  High in DONE.
- pass_out  output  1  Valid with done_out. High only for a completed, unaborted run with zero errors.
- aborted_out  output  1  High in DONE if the run was aborted.
- err_count_out  output  ERR_W  Number of mismatching vectors in the current or last run.
- first_fail_vec_out  output  8  First vector that mismatched.
- first_fail_valid_out  output  1  High once first_fail_vec_out has been captured.

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE → APPLY on start_in. This clears the vector counter, err_count, first_fail_valid, pass, aborted and the settle counter.
- APPLY (1 cycle): stim_out is the current vector. Next state is SETTLE, or CHECK directly if SETTLE_CYCLES = 0.
- SETTLE (SETTLE_CYCLES cycles): stim_out holds.
- CHECK (1 cycle): sample both outputs and compare against the expected values:
  - exp6 = &stim_out[3:0]
  - exp8 = &stim_out[7:4]
- Mismatch handling in CHECK:
  - A mismatch on either output or both increments err_count by exactly 1 per vector, saturating.
  - The first mismatch of a run captures stim_out into first_fail_vec_out and sets first_fail_valid_out.
- CHECK exit:
  - Vector 0xFF → DONE.
  - Otherwise the vector increments → APPLY.
- DONE:
  - stim_out = 0x00, busy_out = 0, done_out = 1.
  - pass_out = (err_count == 0) && !aborted.
  - Results hold until the next accepted start.
- DONE → APPLY on start_in, with the same clears as IDLE → APPLY.
- abort_in in APPLY, SETTLE or CHECK: next state DONE with aborted_out = 1 and pass_out = 0. A CHECK cycle coincident with abort does not update err_count. abort_in in IDLE or DONE is ignored.
- Vector counter is 9 bits internally, so 0xFF is detected without wrapping to 0.

## Timing
- Reset values: all outputs 0, state IDLE, stim_out 0x00.
- Reset asserted mid-run returns the block to IDLE immediately with all results cleared.
- Let edge N be the edge that samples start_in = 1. Then:
  - stim_out = 0x00 and busy_out = 1 after edge N.
  - Vector v is applied after edge N + v·(SETTLE_CYCLES+2).
  - Vector v is sampled at edge N + v·(SETTLE_CYCLES+2) + SETTLE_CYCLES + 1.
  - done_out rises after edge N + 256·(SETTLE_CYCLES+2). That is 1024 cycles at the default setting.
- Outputs of the ic7421 instance must be stable within SETTLE_CYCLES+1 cycles of stim_out changing.
- start_in held high through DONE restarts the block on the first DONE edge. done_out is then high for exactly one cycle.

## Structure
- Package ic7421_bist_pkg holds:
  - The state enum.
  - NUM_VECTORS = 256.
  - Bit-index constants for the eight stim bits.
  - The expected-output function.
- Sub-module ic7421_ref_model: combinational golden model, 8-bit vector in, exp6/exp8 out. It is reusable by benches as a scoreboard.

## Test plan
- Fault-free ic7421 connected, start at default settings → done after 1024 cycles with:
  - pass_out = 1, err_count = 0, first_fail_valid = 0.
- y_out_6_in forced 0 → 16 errors; first_fail_vec = 0x0F, pass_out = 0.
- y_out_8_in forced 1, ERR_W = 4 → err_count saturates at 15; first_fail_vec = 0x00.
- abort_in pulsed at vector 0x40 → DONE next cycle with:
  - aborted_out = 1, pass_out = 0, stim_out = 0x00.
  - A subsequent start reruns from 0x00 with all results cleared.
- start_in pulsed mid-run is ignored and timing is unchanged. rst_n_in pulsed low mid-run → outputs immediately 0 and state IDLE.
- SETTLE_CYCLES = 0 → done after 512 cycles, pass_out = 1.
